// File: rtl/regfile_sb.sv
// Multi-port integer register file: NRP combinational read ports with same-cycle
// write bypass, NWP write ports, a per-register busy scoreboard and a post-reset clear sweep.
module regfile_sb #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter int ADDR_SIZE = 5,
  parameter int NRP       = 2,
  parameter int NWP       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NRP*ADDR_SIZE-1:0] rd_addr,
  output logic [NRP*XLEN-1:0]      rd_data,
  output logic [NRP-1:0]           rd_busy,
  input  logic [NWP-1:0]           wr_en,
  input  logic [NWP*ADDR_SIZE-1:0] wr_addr,
  input  logic [NWP*XLEN-1:0]      wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_SIZE-1:0]     iss_rd,
  output logic [REG_NUM-1:0]       sb_busy,
  output logic                     dbg_state_o
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   idx_q, idx_d;
  logic                   init_done_q, init_done_d;
  logic [XLEN-1:0]        regs_q [REG_NUM];
  logic [XLEN-1:0]        regs_d [REG_NUM];
  logic [REG_NUM-1:0]     busy_q, busy_d;
  logic [NWP-1:0]         wr_ok;
  logic                   ready;

  // True for an architectural, writable register (not x0, not past REG_NUM).
  function automatic logic addr_ok(input logic [ADDR_SIZE-1:0] a);
    return (a != '0) && (int'(a) < REG_NUM);
  endfunction

  assign ready       = (state_q == READY);
  assign init_done   = init_done_q;
  assign sb_busy     = busy_q;
  assign dbg_state_o = state_q;

  always_comb begin
    for (int j = 0; j < NWP; j++) begin
      wr_ok[j] = ready && wr_en[j] && addr_ok(wr_addr[j*ADDR_SIZE +: ADDR_SIZE]);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + ADDR_SIZE'(1);
        if (idx_q == ADDR_SIZE'(REG_NUM - 1)) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Later write ports overwrite earlier ones, so the highest-index port wins a collision.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      regs_d[r] = regs_q[r];
      if (!ready && idx_q == ADDR_SIZE'(r)) regs_d[r] = '0;
      for (int j = 0; j < NWP; j++) begin
        if (wr_ok[j] && wr_addr[j*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r)) begin
          regs_d[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Issue is applied after the write clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < REG_NUM; r++) begin
      for (int j = 0; j < NWP; j++) begin
        if (wr_ok[j] && wr_addr[j*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r)) busy_d[r] = 1'b0;
      end
      if (ready && iss_en && addr_ok(iss_rd) && iss_rd == ADDR_SIZE'(r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      busy_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) regs_q <= regs_d;
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [ADDR_SIZE-1:0] a;
    logic [XLEN-1:0]      d;
    logic                 hit;

    assign a = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];

    always_comb begin
      d   = '0;
      hit = 1'b0;
      if (ready && addr_ok(a)) begin
        d = regs_q[a];
        for (int j = 0; j < NWP; j++) begin
          if (wr_ok[j] && wr_addr[j*ADDR_SIZE +: ADDR_SIZE] == a) begin
            d   = wr_data[j*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] = d;
    assign rd_busy[i] = ready && addr_ok(a) && busy_q[a] && !hit;
  end

endmodule
